// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding, default widths
// and the pointer-advance helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACKS  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int ACK_PULSE_W = 1;
    localparam int GRANT_W     = 2;

    // A locked winner keeps the pointer; otherwise it moves past the winner.
    function automatic logic [GRANT_W-1:0] next_ptr(
        input logic [GRANT_W-1:0] grant,
        input logic               lock,
        input int                 num_req
    );
        logic [GRANT_W-1:0] nxt;
        if (lock) begin
            nxt = grant;
        end else if (int'(grant) >= (num_req - 1)) begin
            nxt = {GRANT_W{1'b0}};
        end else begin
            nxt = grant + {{(GRANT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping to the lowest set request when nothing at or above ptr is set.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic             hi_found_s;
    logic             lo_found_s;
    logic [IDX_W-1:0] hi_idx_s;
    logic [IDX_W-1:0] lo_idx_s;

    // Lowest set request overall and lowest set request at or above ptr.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {IDX_W{1'b0}};
        lo_idx_s   = {IDX_W{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && !lo_found_s) begin
                lo_found_s = 1'b1;
                lo_idx_s   = IDX_W'(j);
            end else begin
                lo_found_s = lo_found_s;
            end
            if (req[j] && !hi_found_s && (j >= int'(ptr))) begin
                hi_found_s = 1'b1;
                hi_idx_s   = IDX_W'(j);
            end else begin
                hi_found_s = hi_found_s;
            end
        end
    end

    assign winner = hi_found_s ? hi_idx_s : lo_idx_s;
    assign valid  = lo_found_s;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between
// NUM_REQ requesters; each access runs IDLE -> ISSUE -> WAIT -> ACKS.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        WE,
    input  logic [NUM_REQ-1:0]        LOCK,
    input  logic [NUM_REQ*ADDR_W-1:0] ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] WDATA,
    output logic [NUM_REQ-1:0]        ACK,
    output logic [DATA_W-1:0]         RDATA,
    output logic [1:0]                GRANT_ID,
    output logic                      BUSY,
    output logic                      ramEnable,
    output logic                      ramWrite,
    output logic [ADDR_W-1:0]         ramAddr,
    output logic [DATA_W-1:0]         ramDataW,
    input  logic [DATA_W-1:0]         ramDataR
);

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic                 we_q, we_d;
    logic                 lock_q, lock_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic                 ram_en_q, ram_en_d;
    logic                 ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;

    logic [GRANT_W-1:0]   pick_idx_s;
    logic                 pick_valid_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_wdata_s;
    logic                 sel_we_s;
    logic                 sel_lock_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GRANT_W)
    ) u_rr_pick (
        .req    (REQ),
        .ptr    (ptr_q),
        .winner (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // AND-OR mux of the winning requester's attributes.
    always_comb begin
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sel_addr_s  = sel_addr_s  | (ADDR[j*ADDR_W +: ADDR_W]
                          & {ADDR_W{pick_idx_s == GRANT_W'(j)}});
            sel_wdata_s = sel_wdata_s | (WDATA[j*DATA_W +: DATA_W]
                          & {DATA_W{pick_idx_s == GRANT_W'(j)}});
            sel_we_s    = sel_we_s   | (WE[j]   & (pick_idx_s == GRANT_W'(j)));
            sel_lock_s  = sel_lock_s | (LOCK[j] & (pick_idx_s == GRANT_W'(j)));
        end
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        we_d        = we_q;
        lock_d      = lock_q;
        ack_d       = {NUM_REQ{1'b0}};
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d     = ISSUE;
                    grant_d     = pick_idx_s;
                    we_d        = sel_we_s;
                    lock_d      = sel_lock_s;
                    ram_en_d    = 1'b1;
                    ram_we_d    = sel_we_s;
                    ram_addr_d  = sel_addr_s;
                    ram_wdata_d = sel_wdata_s;
                    busy_d      = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                busy_d  = 1'b1;
            end
            WAIT: begin
                state_d = ACKS;
                busy_d  = 1'b1;
                // RAM read data is valid during WAIT; writes leave RDATA alone.
                if (!we_q) begin
                    rdata_d = ramDataR;
                end else begin
                    rdata_d = rdata_q;
                end
                for (int j = 0; j < NUM_REQ; j++) begin
                    ack_d[j] = (grant_q == GRANT_W'(j));
                end
            end
            ACKS: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ptr_d   = next_ptr(grant_q, lock_q, NUM_REQ);
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            ptr_q       <= {GRANT_W{1'b0}};
            grant_q     <= {GRANT_W{1'b0}};
            we_q        <= 1'b0;
            lock_q      <= 1'b0;
            ack_q       <= {NUM_REQ{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            lock_q      <= lock_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ACK       = ack_q;
    assign RDATA     = rdata_q;
    assign GRANT_ID  = grant_q;
    assign BUSY      = busy_q;
    assign ramEnable = ram_en_q;
    assign ramWrite  = ram_we_q;
    assign ramAddr   = ram_addr_q;
    assign ramDataW  = ram_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter with a behavioural
// synchronous RAM (one-cycle read latency).
module tb_mem_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            CLK;
    logic            RESET;
    logic [N-1:0]    REQ;
    logic [N-1:0]    WE;
    logic [N-1:0]    LOCK;
    logic [N*AW-1:0] ADDR;
    logic [N*DW-1:0] WDATA;
    logic [N-1:0]    ACK;
    logic [DW-1:0]   RDATA;
    logic [1:0]      GRANT_ID;
    logic            BUSY;
    logic            ramEnable;
    logic            ramWrite;
    logic [AW-1:0]   ramAddr;
    logic [DW-1:0]   ramDataW;
    logic [DW-1:0]   ramDataR;

    mem_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .LOCK(LOCK),
        .ADDR(ADDR), .WDATA(WDATA), .ACK(ACK), .RDATA(RDATA),
        .GRANT_ID(GRANT_ID), .BUSY(BUSY), .ramEnable(ramEnable),
        .ramWrite(ramWrite), .ramAddr(ramAddr), .ramDataW(ramDataW),
        .ramDataR(ramDataR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] rd_q;
    assign ramDataR = rd_q;

    always @(posedge CLK) begin
        if (ramEnable && ramWrite) begin
            mem[ramAddr] <= ramDataW;
        end else if (ramEnable) begin
            rd_q <= mem[ramAddr];
        end
    end

    int total;
    int bad;

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  we;
        logic [N-1:0]  lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    grant;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one request pattern from IDLE and checks the four-cycle access.
    task automatic run_access(input vec_t v);
        logic [N-1:0] onehot;
        onehot = 3'b001 << v.grant;
        REQ  = v.req;
        WE   = v.we;
        LOCK = v.lock;
        for (int i = 0; i < N; i++) begin
            ADDR[i*AW +: AW]  = v.addr + 16'(i);
            WDATA[i*DW +: DW] = v.wdata + 16'(i);
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("issue_en",    32'(ramEnable), 32'd1);
        chk("issue_we",    32'(ramWrite),  32'(v.we[v.grant]));
        chk("issue_addr",  32'(ramAddr),   32'(v.addr + 16'(v.grant)));
        chk("issue_wdata", 32'(ramDataW),  32'(v.wdata + 16'(v.grant)));
        chk("issue_grant", 32'(GRANT_ID),  32'(v.grant));
        chk("issue_busy",  32'(BUSY),      32'd1);
        chk("issue_ack",   32'(ACK),       32'd0);
        // In-flight access must ignore input changes after the IDLE sample.
        WE   = ~v.we;
        LOCK = ~v.lock;
        ADDR  = {16'hDEAD, 16'hBEAD, 16'hFEED};
        WDATA = {16'h0BAD, 16'h0BAD, 16'h0BAD};
        @(negedge CLK);
        chk("wait_en",  32'(ramEnable), 32'd0);
        chk("wait_ack", 32'(ACK),       32'd0);
        @(negedge CLK);
        chk("ack_pulse", 32'(ACK),      32'(onehot));
        chk("ack_rdata", 32'(RDATA),    32'(v.rdata));
        chk("ack_grant", 32'(GRANT_ID), 32'(v.grant));
        REQ  = '0;
        WE   = '0;
        LOCK = '0;
        @(negedge CLK);
        chk("post_ack",  32'(ACK),  32'd0);
        chk("post_busy", 32'(BUSY), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rd_q  = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0100] = 16'hA000;
        mem[16'h0101] = 16'hA001;
        mem[16'h0102] = 16'hA002;

        //          req     we      lock    addr      wdata     g     rdata
        vecs[0]  = '{3'b001, 3'b000, 3'b000, 16'h0010, 16'h0000, 2'd0, 16'hBEEF};
        vecs[1]  = '{3'b010, 3'b010, 3'b000, 16'h01FF, 16'h1233, 2'd1, 16'hBEEF};
        vecs[2]  = '{3'b010, 3'b000, 3'b000, 16'h01FF, 16'h0000, 2'd1, 16'h1234};
        vecs[3]  = '{3'b100, 3'b000, 3'b000, 16'h0000, 16'h0000, 2'd2, 16'h0000};
        vecs[4]  = '{3'b111, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd0, 16'hA000};
        vecs[5]  = '{3'b111, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd1, 16'hA001};
        vecs[6]  = '{3'b111, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd2, 16'hA002};
        vecs[7]  = '{3'b111, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd0, 16'hA000};
        vecs[8]  = '{3'b100, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd2, 16'hA002};
        vecs[9]  = '{3'b011, 3'b000, 3'b001, 16'h0100, 16'h0000, 2'd0, 16'hA000};
        vecs[10] = '{3'b011, 3'b000, 3'b001, 16'h0100, 16'h0000, 2'd0, 16'hA000};
        vecs[11] = '{3'b011, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd0, 16'hA000};
        vecs[12] = '{3'b011, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd1, 16'hA001};
        vecs[13] = '{3'b101, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd2, 16'hA002};
        vecs[14] = '{3'b101, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd0, 16'hA000};
        vecs[15] = '{3'b100, 3'b100, 3'b100, 16'h0300, 16'h5550, 2'd2, 16'hA000};
        vecs[16] = '{3'b101, 3'b000, 3'b000, 16'h0300, 16'h0000, 2'd2, 16'h5552};

        RESET = 1'b0;
        REQ   = '0;
        WE    = '0;
        LOCK  = '0;
        ADDR  = '0;
        WDATA = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_ack",   32'(ACK),       32'd0);
        chk("rst_rdata", 32'(RDATA),     32'd0);
        chk("rst_grant", 32'(GRANT_ID),  32'd0);
        chk("rst_busy",  32'(BUSY),      32'd0);
        chk("rst_en",    32'(ramEnable), 32'd0);
        chk("rst_we",    32'(ramWrite),  32'd0);
        chk("rst_addr",  32'(ramAddr),   32'd0);
        chk("rst_wdata", 32'(ramDataW),  32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        for (int k = 0; k < 17; k++) begin
            run_access(vecs[k]);
        end

        // Idle: nothing requested, nothing happens on the RAM side.
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            chk("idle_busy", 32'(BUSY),      32'd0);
            chk("idle_en",   32'(ramEnable), 32'd0);
        end

        // Reset asserted during WAIT of a read by requester 1.
        REQ  = 3'b010;
        ADDR = {16'h0012, 16'h0011, 16'h0010};
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_issue_grant", 32'(GRANT_ID), 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_ack",   32'(ACK),       32'd0);
        chk("abort_busy",  32'(BUSY),      32'd0);
        chk("abort_rdata", 32'(RDATA),     32'd0);
        chk("abort_grant", 32'(GRANT_ID),  32'd0);
        chk("abort_en",    32'(ramEnable), 32'd0);
        chk("abort_addr",  32'(ramAddr),   32'd0);
        chk("abort_wdata", 32'(ramDataW),  32'd0);
        REQ = 3'b100;
        @(negedge CLK);
        chk("abort_ack_hold", 32'(ACK), 32'd0);
        RESET = 1'b1;
        run_access('{3'b100, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd2, 16'hA002});
        run_access('{3'b101, 3'b000, 3'b000, 16'h0100, 16'h0000, 2'd0, 16'hA000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
